gt_sort_ctrl: RTL and testbench
===============================

# gt_sort_ctrl

Sequencer that sorts a block of N 4-bit words in ascending order by time-sharing a single `gt_4bit` comparator instance. It accepts words over a valid/ready input stream and bubble-sorts them in an internal register array, one compare/swap per cycle. It then streams the sorted words out over a valid/ready output. It sits between a producer of unsigned 4-bit samples and any consumer that needs ordered data, such as a min/max or median stage.

## Interface
- `N`, default 4: words per block; legal range 2..8.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_ready`  output  1  block accepts a word this cycle (LOAD state only).
- `in_data`  input  4  unsigned input word.
- `out_valid`  output  1  `out_data` holds a sorted word (OUT state only).
- `out_ready`  input  1  consumer accepts `out_data` this cycle.
- `out_data`  output  4  current sorted word.
- `out_last`  output  1  high with `out_valid` on the N-th (largest) word.
- `busy`  output  1  high in SORT state.

## Operation
- Storage is `mem[0..N-1]`, 4 bits each. Index counters are `wr_idx`, `cmp_idx` (0..N-2), `pass_cnt` (0..N-2) and `rd_idx`, each `$clog2(N)` bits wide or wider.
- One `gt_4bit` instance compares `a = mem[cmp_idx]` with `b = mem[cmp_idx+1]`. No other magnitude comparison is permitted in the sort path.
- The state machine has three states: LOAD, SORT and OUT.
- **LOAD**
  - `in_ready` is 1.
  - On `in_valid && in_ready`, write `mem[wr_idx] <= in_data` and increment `wr_idx`.
  - On the handshake with `wr_idx == N-1`, go to SORT and clear `cmp_idx`, `pass_cnt` and the swap flag.
- **SORT**
  - `busy` is 1 and `in_ready` is 0.
  - Each cycle, if `agtb` is 1, swap `mem[cmp_idx]` and `mem[cmp_idx+1]` in the same edge and set the swap flag.
  - Equal words are never swapped, because the comparison is strict.
  - `cmp_idx` increments each cycle.
  - At `cmp_idx == N-2`, the pass ends: wrap `cmp_idx` to 0, increment `pass_cnt`, and evaluate the exit condition (see Configuration).
  - On exit, go to OUT and clear `rd_idx`.
- **OUT**
  - `out_valid` is 1 and `out_data = mem[rd_idx]`.
  - `out_last = (rd_idx == N-1)`.
  - On `out_valid && out_ready`, increment `rd_idx`.
  - On the handshake with `rd_idx == N-1`, go to LOAD and clear `wr_idx`.
- `in_valid` outside LOAD is ignored and no data is lost. The producer must hold its data until it sees `in_ready`.

## Timing
- Reset (`rst_n == 0` at a rising edge):
  - state goes to LOAD; all counters and `mem` are cleared to 0.
  - After that edge: `in_ready` = 1, `out_valid` = 0, `out_last` = 0, `busy` = 0, `out_data` = 0.
- Reset during any state, including mid-SORT or mid-OUT, discards the block and has the same result.
- `in_ready`, `out_valid`, `out_last` and `busy` are decoded from registered state only. None of them depends combinationally on `in_valid` or `out_ready`.
- LOAD to SORT: `busy` rises in the cycle after the N-th input handshake.
- SORT to OUT: `out_valid` rises in the cycle after the final compare.
- SORT length:
  - Without early exit: exactly (N-1)×(N-1) cycles.
  - With early exit: k×(N-1) cycles, where k is the index of the first swap-free pass and k ≤ N-1.
- Output:
  - With `out_ready` held high, one word per cycle, N cycles in total.
  - While `out_ready` = 0, `out_data` and `out_last` hold stable.
- OUT to LOAD: `in_ready` rises in the cycle after the last output handshake. No back-to-back overlap between blocks.

## Configuration
- Macro: `GT_SORT_EARLY_EXIT_EN`.
- Defined:
  - At each pass end, go to OUT if the swap flag is 0 or `pass_cnt` has reached N-1.
  - Clear the swap flag at every pass start.
- Undefined:
  - The swap flag is not implemented.
  - Go to OUT only when `pass_cnt` reaches N-1, giving a fixed, data-independent latency.

## Test plan
- Load 3,1,2,0 with N=4 and `out_ready`=1 → outputs 0,1,2,3 on consecutive cycles, with `out_last` only on 3. `busy` is high for 9 cycles without the macro.
- Load 0,1,2,3 → outputs 0,1,2,3. `busy` is high for 3 cycles with `GT_SORT_EARLY_EXIT_EN` and 9 cycles without it.
- Load 5,5,15,0 → outputs 0,5,5,15. This confirms equal words are not swapped and duplicates are preserved.
- During OUT, hold `out_ready`=0 for 5 cycles with `out_data`=0 showing → `out_data` stays 0 and `out_valid` stays 1. Toggling `in_valid` meanwhile has no effect, and `in_ready` stays 0.
- Assert `rst_n`=0 for one edge in the 4th SORT cycle → next cycle `in_ready`=1, `busy`=0, `out_valid`=0. A fresh load of 15,14,13,12 then outputs 12,13,14,15.
- Run two blocks back-to-back, 9,8,7,6 then 1,0,1,0 → outputs 6,7,8,9 then 0,0,1,1. `in_ready` rises exactly one cycle after the 9 handshake.

Source files
------------

// File: rtl/gt_sort_ctrl.sv
// gt_sort_ctrl -- block sorter for unsigned 4-bit words.
//
// Accepts N words over a valid/ready input stream, bubble-sorts them in
// place using a single time-shared gt_4bit comparator (one compare/swap per
// cycle), then streams them out in ascending order over valid/ready.
//
// Optional feature macro: GT_SORT_EARLY_EXIT_EN
//   defined   : a pass with no swap ends the sort early (data-dependent latency)
//   undefined : always N-1 full passes ((N-1)*(N-1) cycles, fixed latency)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   producer word valid
//   in_ready   out  word accepted this cycle (LOAD only)
//   in_data    in   4-bit unsigned input word
//   out_valid  out  out_data holds a sorted word (OUT only)
//   out_ready  in   consumer accepts out_data
//   out_data   out  current sorted word
//   out_last   out  high on the N-th (largest) word
//   busy       out  high while sorting

// Strict unsigned a > b built from per-bit greater/equal terms, MSB first.
module gt_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       agtb
);
  logic [3:0] gt_bit;
  logic [3:0] eq_bit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign gt_bit[gi] = a[gi] & ~b[gi];
    assign eq_bit[gi] = ~(a[gi] ^ b[gi]);
  end

  assign agtb = gt_bit[3]
              | (eq_bit[3] & gt_bit[2])
              | (eq_bit[3] & eq_bit[2] & gt_bit[1])
              | (eq_bit[3] & eq_bit[2] & eq_bit[1] & gt_bit[0]);
endmodule

module gt_sort_ctrl #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_last,
  output logic       busy
);
  localparam int            IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] CMP_END  = IW'(N - 2);
  localparam logic [IW-1:0] ONE      = IW'(1);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mem_q [N];
  logic [3:0]    mem_d [N];
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] cmp_idx_q, cmp_idx_d;
  logic [IW-1:0] pass_cnt_q, pass_cnt_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
`ifdef GT_SORT_EARLY_EXIT_EN
  logic          swap_q, swap_d;
`endif

  logic [IW-1:0] cmp_nxt;
  logic [IW-1:0] pass_nxt;
  logic [3:0]    cmp_a;
  logic [3:0]    cmp_b;
  logic          agtb;
  logic          pass_exit;

  assign cmp_nxt  = cmp_idx_q + ONE;
  assign pass_nxt = pass_cnt_q + ONE;
  assign cmp_a    = mem_q[cmp_idx_q];
  assign cmp_b    = mem_q[cmp_nxt];

  gt_4bit u_gt (
    .a    (cmp_a),
    .b    (cmp_b),
    .agtb (agtb)
  );

  // A swap in the final compare of a pass still counts for that pass.
`ifdef GT_SORT_EARLY_EXIT_EN
  assign pass_exit = !(swap_q || agtb) || (pass_nxt == LAST_IDX);
`else
  assign pass_exit = (pass_nxt == LAST_IDX);
`endif

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_idx_d   = wr_idx_q;
    cmp_idx_d  = cmp_idx_q;
    pass_cnt_d = pass_cnt_q;
    rd_idx_d   = rd_idx_q;
`ifdef GT_SORT_EARLY_EXIT_EN
    swap_d     = swap_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          mem_d[wr_idx_q] = in_data;
          if (wr_idx_q == LAST_IDX) begin
            state_d    = S_SORT;
            wr_idx_d   = '0;
            cmp_idx_d  = '0;
            pass_cnt_d = '0;
`ifdef GT_SORT_EARLY_EXIT_EN
            swap_d     = 1'b0;
`endif
          end else begin
            wr_idx_d = wr_idx_q + ONE;
          end
        end
      end
      S_SORT: begin
        if (agtb) begin
          mem_d[cmp_idx_q] = cmp_b;
          mem_d[cmp_nxt]   = cmp_a;
`ifdef GT_SORT_EARLY_EXIT_EN
          swap_d           = 1'b1;
`endif
        end
        if (cmp_idx_q == CMP_END) begin
          cmp_idx_d  = '0;
          pass_cnt_d = pass_nxt;
`ifdef GT_SORT_EARLY_EXIT_EN
          swap_d     = 1'b0;
`endif
          if (pass_exit) begin
            state_d    = S_OUT;
            rd_idx_d   = '0;
            pass_cnt_d = '0;
          end
        end else begin
          cmp_idx_d = cmp_nxt;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d  = S_LOAD;
            wr_idx_d = '0;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + ONE;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      wr_idx_q   <= '0;
      cmp_idx_q  <= '0;
      pass_cnt_q <= '0;
      rd_idx_q   <= '0;
`ifdef GT_SORT_EARLY_EXIT_EN
      swap_q     <= 1'b0;
`endif
      for (int i = 0; i < N; i++) mem_q[i] <= 4'd0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      cmp_idx_q  <= cmp_idx_d;
      pass_cnt_q <= pass_cnt_d;
      rd_idx_q   <= rd_idx_d;
`ifdef GT_SORT_EARLY_EXIT_EN
      swap_q     <= swap_d;
`endif
      for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Handshake/status outputs come from registered state only.
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_SORT);
  assign out_valid = (state_q == S_OUT);
  assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
  assign out_data  = out_valid ? mem_q[rd_idx_q] : 4'd0;
endmodule

// File: tb/tb_gt_sort_ctrl.sv
// Testbench for gt_sort_ctrl: scoreboard-based. The driver pushes the
// expected sorted block and expected sort length when a block is issued;
// a monitor compares whatever the DUT presents at each falling edge.
module tb_gt_sort_ctrl;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last, busy;
  logic [3:0] out_data;

  gt_sort_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_data_q[$];
  int exp_busy_q[$];
  int rdy_mode = 2;  // 0 random, 1 force low, 2 force high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Bubble sort moves each element left at most one slot per pass, so the
  // number of passes that swap equals the largest count of bigger words
  // ahead of any word; the next pass is the first swap-free one.
  function automatic int busy_len(input int blk[N]);
`ifdef GT_SORT_EARLY_EXIT_EN
    int d = 0;
    int k;
    for (int i = 0; i < N; i++) begin
      int c = 0;
      for (int j = 0; j < i; j++) if (blk[j] > blk[i]) c++;
      if (c > d) d = c;
    end
    k = d + 1;
    if (k > N - 1) k = N - 1;
    return k * (N - 1);
`else
    return (N - 1) * (N - 1);
`endif
  endfunction

  task automatic send_block(input int blk[N]);
    int s[$];
    logic hs;
    int guard;
    for (int i = 0; i < N; i++) s.push_back(blk[i]);
    s.sort();
    foreach (s[i]) exp_data_q.push_back(s[i]);
    exp_busy_q.push_back(busy_len(blk));
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = 4'(blk[i]);
      guard = 0;
      hs = 1'b0;
      while (!hs) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk); #1;
        guard++;
        if (guard > 2000) begin
          errors++;
          $display("FAIL in_handshake_timeout: got no in_ready expected in_ready=1");
          finish_run();
        end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_after_load", busy, 1);
    check("in_ready_in_sort", in_ready, 0);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_data_q.size() != 0) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 5000) begin
        errors++;
        $display("FAIL drain_timeout: got %0d words left expected 0", exp_data_q.size());
        finish_run();
      end
    end
    @(posedge clk); #1;
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard
  int         pos = 0;
  int         busy_run = 0;
  logic       stalled = 1'b0;
  logic       chk_ir = 1'b0;
  logic [3:0] prev_data = 4'd0;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pos = 0; busy_run = 0; stalled = 1'b0; chk_ir = 1'b0;
    end else begin
      if (chk_ir) begin
        check("in_ready_after_last", in_ready, 1);
        check("out_valid_after_last", out_valid, 0);
        chk_ir = 1'b0;
      end
      if (stalled && out_valid) begin
        check("stall_data_stable", out_data, prev_data);
        check("stall_last_stable", out_last, prev_last);
      end
      if (out_valid) check("out_last", out_last, (pos == N - 1));
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL out_unexpected: got word %0d expected no output", out_data);
        end else begin
          int e;
          e = exp_data_q.pop_front();
          check("out_data", out_data, e);
        end
        if (pos == N - 1) begin pos = 0; chk_ir = 1'b1; end
        else pos++;
      end
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (busy) busy_run++;
      else if (busy_run > 0) begin
        check("out_valid_after_sort", out_valid, 1);
        if (exp_busy_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL busy_unexpected: got run %0d expected none", busy_run);
        end else begin
          int eb;
          eb = exp_busy_q.pop_front();
          check("busy_cycles", busy_run, eb);
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int blk[N];
    int guard;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    rdy_mode = 2;
    send_block('{3, 1, 2, 0});
    send_block('{0, 1, 2, 3});
    send_block('{5, 5, 15, 0});
    drain();

    // Output stall with in_valid toggling
    rdy_mode = 1;
    send_block('{3, 1, 2, 0});
    guard = 0;
    while (!out_valid) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        errors++;
        $display("FAIL out_valid_timeout: got 0 expected 1");
        finish_run();
      end
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_data  = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("stall_out_data", out_data, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    drain();

    // Reset in the 4th SORT cycle
    send_block('{9, 3, 7, 1});
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_data_q.delete();
    exp_busy_q.delete();
    @(negedge clk);
    check("midsort_rst_in_ready", in_ready, 1);
    check("midsort_rst_busy", busy, 0);
    check("midsort_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    send_block('{15, 14, 13, 12});
    drain();

    // Back-to-back blocks
    send_block('{9, 8, 7, 6});
    send_block('{1, 0, 1, 0});
    drain();

    // Random blocks with random back-pressure
    rdy_mode = 0;
    for (int b = 0; b < 20; b++) begin
      foreach (blk[i]) blk[i] = $urandom_range(0, 15);
      send_block(blk);
    end
    drain();
    rdy_mode = 2;
    repeat (3) begin @(posedge clk); #1; end
    check("final_busy_queue_empty", exp_busy_q.size(), 0);
    finish_run();
  end
endmodule
